// File: rtl/pfu_update_ctrl.sv
// pfu_update_ctrl
// Pauli-frame update sequencer for a bank of NUM_QB logical qubits.
// Two requester streams (merged codewords from decode, 2-bit error
// corrections from the decoder) share one two-edge read-modify-write
// datapath over the PF storage. The block also streams the frame out
// (sweep, optionally zeroing each entry as it leaves) and clears it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cwd_valid/ready/qidx/data     codeword request stream
//   err_valid/ready/qidx/data     error-correction request stream
//   clear                         pulse: zero every PF entry
//   sweep_start, sweep_clr        pulse: stream all PFs out (clr: zero on emit)
//   pf_out_valid/ready/qidx/data  sweep output stream
//   busy                          not idle in RUN, or an update in flight
module pfu_update_ctrl #(
  parameter int NUM_QB  = 16,
  parameter int QIDX_BW = 4,
  parameter int CWD_BW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cwd_valid,
  output logic               cwd_ready,
  input  logic [QIDX_BW-1:0] cwd_qidx,
  input  logic [CWD_BW-1:0]  cwd_data,
  input  logic               err_valid,
  output logic               err_ready,
  input  logic [QIDX_BW-1:0] err_qidx,
  input  logic [1:0]         err_data,
  input  logic               clear,
  input  logic               sweep_start,
  input  logic               sweep_clr,
  output logic               pf_out_valid,
  input  logic               pf_out_ready,
  output logic [QIDX_BW-1:0] pf_out_qidx,
  output logic [1:0]         pf_out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_SWEEP = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [QIDX_BW-1:0] LAST_IDX = QIDX_BW'(NUM_QB - 1);
  localparam logic [CWD_BW-1:0]  CWD_H    = CWD_BW'(4);
  localparam logic [CWD_BW-1:0]  CWD_CX   = CWD_BW'(5);

  state_t               r_state;
  state_t               w_state_next;

  // Stage 1 of the update pipeline: request accepted on the previous edge.
  logic                 r_s1_valid;
  logic                 r_s1_sel_err;
  logic [QIDX_BW-1:0]   r_s1_qidx;
  logic [CWD_BW-1:0]    r_s1_code;

  logic                 r_rr_cwd;      // 1: cwd wins the next contested cycle
  logic                 r_cmd_clear;   // command latched on the way into DRAIN
  logic                 r_sweep_clr;
  logic [QIDX_BW-1:0]   r_idx;

  logic [1:0]           r_pf_mem [NUM_QB];
  logic [1:0]           w_pf_next [NUM_QB];

  logic                 w_sweep_hs;
  logic                 w_sweep_zero;
  logic                 w_clear_all;
  logic [1:0]           w_s1_old;
  logic [1:0]           w_s1_new;

  // ---------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    cwd_ready    = 1'b0;
    err_ready    = 1'b0;
    pf_out_valid = 1'b0;
    pf_out_qidx  = '0;
    pf_out_data  = 2'b00;
    w_sweep_hs   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (clear || sweep_start) begin
          w_state_next = S_DRAIN;
        end else begin
          cwd_ready = cwd_valid & (!err_valid | r_rr_cwd);
          err_ready = err_valid & (!cwd_valid | !r_rr_cwd);
        end
      end
      S_DRAIN: w_state_next = r_cmd_clear ? S_CLEAR : S_SWEEP;
      S_CLEAR: w_state_next = S_RUN;
      S_SWEEP: begin
        pf_out_valid = 1'b1;
        pf_out_qidx  = r_idx;
        pf_out_data  = r_pf_mem[r_idx];
        if (pf_out_ready) begin
          w_sweep_hs = 1'b1;
          if (r_idx == LAST_IDX) w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_RUN;
    endcase
    // Keep the interface quiet while reset is held so nothing handshakes
    // on the edge that is about to wipe the state.
    if (rst) begin
      cwd_ready    = 1'b0;
      err_ready    = 1'b0;
      pf_out_valid = 1'b0;
      pf_out_qidx  = '0;
      pf_out_data  = 2'b00;
      w_sweep_hs   = 1'b0;
    end
  end

  assign busy = (r_state != S_RUN) | r_s1_valid;

  // ---------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_s1_valid   <= 1'b0;
      r_s1_sel_err <= 1'b0;
      r_s1_qidx    <= '0;
      r_s1_code    <= '0;
      r_rr_cwd     <= 1'b1;
      r_cmd_clear  <= 1'b0;
      r_sweep_clr  <= 1'b0;
      r_idx        <= '0;
    end else begin
      r_state    <= w_state_next;
      r_s1_valid <= cwd_ready | err_ready;
      if (cwd_ready) begin
        r_s1_sel_err <= 1'b0;
        r_s1_qidx    <= cwd_qidx;
        r_s1_code    <= cwd_data;
      end else if (err_ready) begin
        r_s1_sel_err <= 1'b1;
        r_s1_qidx    <= err_qidx;
        r_s1_code    <= {{(CWD_BW-2){1'b0}}, err_data};
      end
      // Only a contested grant moves the pointer.
      if (cwd_valid && err_valid && (cwd_ready || err_ready)) begin
        r_rr_cwd <= ~r_rr_cwd;
      end
      // clear wins over a simultaneous sweep_start; the sweep is dropped.
      if (r_state == S_RUN && (clear || sweep_start)) begin
        r_cmd_clear <= clear;
        r_sweep_clr <= sweep_clr & ~clear;
      end
      if (r_state == S_DRAIN) begin
        r_idx <= '0;
      end else if (w_sweep_hs && r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage-1 update function
  // ---------------------------------------------------------------
  assign w_s1_old = r_pf_mem[r_s1_qidx];

  always_comb begin
    w_s1_new = w_s1_old;
    if (r_s1_sel_err || r_s1_code < CWD_H) begin
      w_s1_new = w_s1_old ^ r_s1_code[1:0];
    end else if (r_s1_code == CWD_H) begin
      // Hadamard swaps X and Z: exchanging the two bits maps 01<->10
      // and leaves 00 and 11 alone.
      w_s1_new = {w_s1_old[0], w_s1_old[1]};
    end else if (r_s1_code == CWD_CX) begin
      w_s1_new = 2'b00;
    end
  end

  // ---------------------------------------------------------------
  // PF storage: per-entry next value. Stage 1 never overlaps CLEAR or
  // SWEEP because DRAIN lets it retire first, so the priority order only
  // matters for robustness.
  // ---------------------------------------------------------------
  assign w_clear_all  = (r_state == S_CLEAR);
  assign w_sweep_zero = w_sweep_hs & r_sweep_clr;

  generate
    for (genvar gi = 0; gi < NUM_QB; gi++) begin : g_pf_next
      assign w_pf_next[gi] =
        w_clear_all                                        ? 2'b00    :
        (w_sweep_zero && r_idx == QIDX_BW'(gi))            ? 2'b00    :
        (r_s1_valid && r_s1_qidx == QIDX_BW'(gi))          ? w_s1_new :
                                                             r_pf_mem[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_QB; i++) r_pf_mem[i] <= 2'b00;
    end else begin
      for (int i = 0; i < NUM_QB; i++) r_pf_mem[i] <= w_pf_next[i];
    end
  end

endmodule
